// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload layouts for each stage boundary.
// Each stage packs its fields into one of these structs and passes the
// packed vector through a pipe_stage_reg of matching width.
package pipe_pkg;

  // EX/MEM boundary: ALU result, store data, destination register, PC+4.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } ex_mem_t;

  localparam int EX_MEM_W = 101;

  // IF/ID boundary: fetched instruction and its PC values.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // ID/EX boundary: operands, immediate, destination and control bits.
  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [31:0] pc_plus4;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

  // MEM/WB boundary: value to write back and where.
  typedef struct packed {
    logic [31:0] wb_value;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Increment on each qualifying cycle until the counter is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs the one payload
// that can arrive after the downstream stalls, so in_ready is a plain flop.
// Optional performance counters (stall_cnt, bubble_cnt) are built when the
// macro PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = EX_MEM_W,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_CNT_EN
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  logic              main_v_reg, main_v_next;
  logic              skid_v_reg, skid_v_next;
  logic [DATA_W-1:0] main_d_reg, main_d_next;
  logic [DATA_W-1:0] skid_d_reg, skid_d_next;
  logic              accept;
  logic              drain;

  assign in_ready  = !skid_v_reg;
  assign out_valid = main_v_reg;
  assign out_data  = main_d_reg;

  assign accept = in_valid && !skid_v_reg;
  assign drain  = main_v_reg && out_ready;

  // Next-state rules in priority order: flush, skid refill, pass-through
  // accept, overflow into skid, drain to empty, hold.
  always_comb begin
    main_v_next = main_v_reg;
    skid_v_next = skid_v_reg;
    main_d_next = main_d_reg;
    skid_d_next = skid_d_reg;
    if (flush) begin
      main_v_next = 1'b0;
      skid_v_next = 1'b0;
      if (CLEAR_DATA != 0) begin
        main_d_next = '0;
        skid_d_next = '0;
      end
    end else if (skid_v_reg && out_ready) begin
      // in_ready is low here, so no new payload can collide with the move.
      main_v_next = 1'b1;
      main_d_next = skid_d_reg;
      skid_v_next = 1'b0;
      if (CLEAR_DATA != 0) begin
        skid_d_next = '0;
      end
    end else if (accept && (!main_v_reg || out_ready)) begin
      main_v_next = 1'b1;
      main_d_next = in_data;
    end else if (accept && main_v_reg && !out_ready) begin
      skid_v_next = 1'b1;
      skid_d_next = in_data;
    end else if (drain) begin
      main_v_next = 1'b0;
      if (CLEAR_DATA != 0) begin
        main_d_next = '0;
      end
    end
  end

  // Entry registers; reset drops both entries immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_reg <= 1'b0;
      skid_v_reg <= 1'b0;
      main_d_reg <= '0;
      skid_d_reg <= '0;
    end else begin
      main_v_reg <= main_v_next;
      skid_v_reg <= skid_v_next;
      main_d_reg <= main_d_next;
      skid_d_reg <= skid_d_next;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Counters sample the state before any flush takes effect.
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = main_v_reg && !out_ready;
  assign bubble_inc = !main_v_reg;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (payload cleared / held on
// bubbles) driven by the same stimulus and compared against a queue model.
module tb_pipe_stage_reg;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0]  out_data1, out_data0;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CW-1:0] stall_cnt1, bubble_cnt1, stall_cnt0, bubble_cnt0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .CLEAR_DATA(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_CNT_EN
    .out_data(out_data1), .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
`else
    .out_data(out_data1)
`endif
  );

  pipe_stage_reg #(.DATA_W(W), .CLEAR_DATA(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_CNT_EN
    .out_data(out_data0), .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`else
    .out_data(out_data0)
`endif
  );

  // Reference model: FIFO of held payloads (capacity 2) and the last payload
  // shown at the head, which the hold-data instance keeps after draining.
  logic [W-1:0] mq[$];
  logic [W-1:0] last0;
  int stall_m, bub_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last0 = '0;
    stall_m = 0;
    bub_m = 0;
  endtask

  task automatic model_edge(input logic iv, input logic orr, input logic fl, input logic [W-1:0] d);
    bit was_full, can_take;
    if (mq.size() == 0) bub_m = (bub_m < 15) ? bub_m + 1 : 15;
    else if (!orr) stall_m = (stall_m < 15) ? stall_m + 1 : 15;
    if (fl) begin
      mq.delete();
    end else begin
      was_full = (mq.size() > 0) && orr;
      can_take = iv && (mq.size() < 2);
      if (was_full) void'(mq.pop_front());
      if (can_take) mq.push_back(d);
    end
    if (mq.size() > 0) last0 = mq[0];
  endtask

  // Apply one cycle of inputs, clock it, and land 1 ns after the edge.
  task automatic step(input logic iv, input logic orr, input logic fl, input logic [W-1:0] d);
    in_valid = iv;
    out_ready = orr;
    flush = fl;
    in_data = d;
    model_edge(iv, orr, fl, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ov"}, {63'd0, out_valid1}, {63'd0, mq.size() > 0});
    chk({tag, "_ir"}, {63'd0, in_ready1}, {63'd0, mq.size() < 2});
    chk({tag, "_od1"}, {32'd0, out_data1}, {32'd0, (mq.size() > 0) ? mq[0] : 32'd0});
    chk({tag, "_od0"}, {32'd0, out_data0}, {32'd0, (mq.size() > 0) ? mq[0] : last0});
    chk({tag, "_ir0"}, {63'd0, in_ready0}, {63'd0, mq.size() < 2});
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk({tag, "_stall"}, {60'd0, stall_cnt1}, 64'(stall_m));
    chk({tag, "_bubble"}, {60'd0, bubble_cnt1}, 64'(bub_m));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // One idle edge passed with empty state: counts one bubble.
    bub_m = 1;
  endtask

  typedef struct {
    logic         iv, orr, fl;
    logic [W-1:0] d;
    logic         ev, eir;
    logic [W-1:0] ed1, ed0;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Backpressure, in-order release, then flush with both entries full.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA,  1'b1, 1'b1, 32'hA,  32'hA};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hB,  1'b1, 1'b0, 32'hA,  32'hA};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hC,  1'b1, 1'b0, 32'hA,  32'hA};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'hC,  1'b1, 1'b1, 32'hB,  32'hB};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'hC,  1'b1, 1'b1, 32'hC,  32'hC};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'hC};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b1, 32'h11, 32'h11};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h12, 1'b1, 1'b0, 32'h11, 32'h11};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'hD,  1'b0, 1'b1, 32'h0,  32'h11};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'h11};

    // Reset state, checked while reset is still asserted.
    #2;
    chk("rst_ov", {63'd0, out_valid1}, 64'd0);
    chk("rst_od", {32'd0, out_data1}, 64'd0);
    chk("rst_ir", {63'd0, in_ready1}, 64'd1);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].orr, tbl[i].fl, tbl[i].d);
      $display("vec %0d: iv=%0b or=%0b fl=%0b d=0x%0h -> ov=%0b od=0x%0h ir=%0b", i,
               tbl[i].iv, tbl[i].orr, tbl[i].fl, tbl[i].d, out_valid1, out_data1, in_ready1);
      chk($sformatf("vec%0d_ov", i), {63'd0, out_valid1}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ir", i), {63'd0, in_ready1}, {63'd0, tbl[i].eir});
      chk($sformatf("vec%0d_od1", i), {32'd0, out_data1}, {32'd0, tbl[i].ed1});
      chk($sformatf("vec%0d_od0", i), {32'd0, out_data0}, {32'd0, tbl[i].ed0});
    end

    // Streaming: one payload per cycle, in_ready stays high.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b0, W'(i));
      $display("stream %0d: od=0x%0h ir=%0b", i, out_data1, in_ready1);
      chk("stream_ov", {63'd0, out_valid1}, 64'd1);
      chk("stream_od", {32'd0, out_data1}, 64'(i));
      chk("stream_ir", {63'd0, in_ready1}, 64'd1);
    end

    // Hold-data drain: 0x55 then idle.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h55);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    $display("drain: ov0=%0b od0=0x%0h od1=0x%0h", out_valid0, out_data0, out_data1);
    chk("drain_ov0", {63'd0, out_valid0}, 64'd0);
    chk("drain_od0", {32'd0, out_data0}, 64'h55);
    chk("drain_od1", {32'd0, out_data1}, 64'h0);

    // Asynchronous reset with both entries full, no clock edge needed.
    step(1'b1, 1'b0, 1'b0, 32'h77);
    step(1'b1, 1'b0, 1'b0, 32'h78);
    chk("full_ir", {63'd0, in_ready1}, 64'd0);
    reset = 1'b1;
    #1;
    $display("async reset: ov=%0b od=0x%0h ir=%0b", out_valid1, out_data1, in_ready1);
    chk("arst_ov", {63'd0, out_valid1}, 64'd0);
    chk("arst_od", {32'd0, out_data1}, 64'd0);
    chk("arst_ir", {63'd0, in_ready1}, 64'd1);
    chk("arst_od0", {32'd0, out_data0}, 64'd0);
    do_reset();

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Saturation: 1 bubble (reset idle) + 1 bubble (load) + 20 stalls.
    step(1'b1, 1'b0, 1'b0, 32'h9);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat_stall", {60'd0, stall_cnt1}, 64'd15);
    chk("sat_bubble", {60'd0, bubble_cnt1}, 64'd2);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    $display("perf: stall=%0d bubble=%0d", stall_cnt1, bubble_cnt1);
    chk("idle_bubble", {60'd0, bubble_cnt1}, 64'd5);
    chk("idle_stall", {60'd0, stall_cnt1}, 64'd15);
    do_reset();
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic iv, orr, fl;
      logic [W-1:0] d;
      iv  = 1'($urandom_range(0, 3) != 0);
      orr = 1'($urandom_range(0, 2) != 0);
      fl  = 1'($urandom_range(0, 19) == 0);
      d   = $urandom;
      step(iv, orr, fl, d);
      $display("rand %0d: iv=%0b or=%0b fl=%0b d=0x%0h -> ov=%0b od=0x%0h ir=%0b", i,
               iv, orr, fl, d, out_valid1, out_data1, in_ready1);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
